// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares one RAM port between instruction fetch and data
//                access. Data has priority; a starvation counter forces an
//                instruction grant after STARVE_MAX consecutive data grants.
//                Also owns the halt drain sequence and a sticky RAM timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    input  logic              halt,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic              ram_ready,
    output logic              halted,
    output logic              err
);

    localparam int c_SC_W = $clog2(STARVE_MAX + 1);
    localparam int c_TC_W = $clog2(TIMEOUT + 1);
    localparam logic [c_SC_W-1:0] c_STARVE_MAX = c_SC_W'(STARVE_MAX);
    localparam logic [c_TC_W-1:0] c_TC_LAST    = c_TC_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_IACC   = 2'd1,
        S_DACC   = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [c_SC_W-1:0]   r_starve_cnt;
    logic [c_TC_W-1:0]   r_tcnt;
    logic                r_halt_pend;

    logic w_in_acc;
    logic w_ready;
    logic w_tout;
    logic w_force_i;

    // A reset in the middle of an access drops it, so completion is masked by RST.
    assign w_in_acc  = (r_state == S_IACC) || (r_state == S_DACC);
    assign w_ready   = w_in_acc && ram_ready && !RST;
    assign w_tout    = w_in_acc && !ram_ready && (r_tcnt == c_TC_LAST);
    assign w_force_i = iREN && (r_starve_cnt == c_STARVE_MAX);

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and combinational completion outputs
    always_comb begin
        w_next = r_state;
        iwait  = 1'b1;
        dwait  = 1'b1;
        iload  = '0;
        dload  = '0;
        halted = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (halt || r_halt_pend) begin
                    w_next = S_HALTED;
                end else if ((dREN || dWEN) && !w_force_i) begin
                    w_next = S_DACC;
                end else if (iREN) begin
                    w_next = S_IACC;
                end
            end
            S_IACC: begin
                if (w_ready) begin
                    iwait  = 1'b0;
                    iload  = ramload;
                    w_next = S_IDLE;
                end else if (w_tout) begin
                    w_next = S_IDLE;
                end
            end
            S_DACC: begin
                if (w_ready) begin
                    dwait  = 1'b0;
                    if (!ramWEN) begin
                        dload = ramload;
                    end
                    w_next = S_IDLE;
                end else if (w_tout) begin
                    w_next = S_IDLE;
                end
            end
            S_HALTED: begin
                halted = 1'b1;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Grant registration, access timer, starvation counter, halt and error flags
    always_ff @(posedge CLK) begin
        if (RST) begin
            ramREN       <= 1'b0;
            ramWEN       <= 1'b0;
            ramaddr      <= '0;
            ramstore     <= '0;
            r_starve_cnt <= '0;
            r_tcnt       <= '0;
            r_halt_pend  <= 1'b0;
            err          <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tcnt <= '0;
                    if (!iREN) begin
                        r_starve_cnt <= '0;
                    end
                    if (w_next == S_DACC) begin
                        ramaddr  <= daddr;
                        ramstore <= dstore;
                        // Write wins when both enables are raised together.
                        ramWEN   <= dWEN;
                        ramREN   <= !dWEN;
                    end else if (w_next == S_IACC) begin
                        ramaddr <= iaddr;
                        ramREN  <= 1'b1;
                        ramWEN  <= 1'b0;
                    end
                end
                S_IACC, S_DACC: begin
                    if (halt) begin
                        r_halt_pend <= 1'b1;
                    end
                    if (w_tout) begin
                        err <= 1'b1;
                    end
                    if (w_next == S_IDLE) begin
                        ramREN <= 1'b0;
                        ramWEN <= 1'b0;
                        r_tcnt <= '0;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                    if (w_ready && (r_state == S_IACC)) begin
                        r_starve_cnt <= '0;
                    end else if (w_ready && iREN && (r_starve_cnt != c_STARVE_MAX)) begin
                        r_starve_cnt <= r_starve_cnt + 1'b1;
                    end
                end
                default: begin
                    ramREN <= 1'b0;
                    ramWEN <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single shared RAM port between the instruction-fetch requester (iREN) and the data-access requester (dREN/dWEN) of the single-cycle datapath.
- Grants one transaction at a time. Data accesses have priority, and a starvation counter guarantees instruction fetch forward progress.
- Sits between the datapath and the RAM model. It also owns the halt drain sequence and a RAM-timeout error flag.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive data grants allowed while iREN is pending before instruction fetch is forced
- TIMEOUT, 64, maximum cycles in an access state without ram_ready before abort

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, synchronous, active-high
- iREN  in  1  instruction read request
- iaddr  in  ADDR_W  instruction address
- iwait  out  1  0 only in the instruction completion cycle
- iload  out  DATA_W  instruction word, valid when iwait=0
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  ADDR_W  data address
- dstore  in  DATA_W  write data
- dwait  out  1  0 only in the data completion cycle
- dload  out  DATA_W  read data, valid when dwait=0
- halt  in  1  drain request
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  ADDR_W  RAM address
- ramstore  out  DATA_W  RAM write data
- ramload  in  DATA_W  RAM read data
- ram_ready  in  1  RAM completes the current access this cycle
- halted  out  1  drain complete
- err  out  1  sticky RAM timeout flag

Behaviour:
- **One clock, reset synchronous active-high.** RST → state IDLE; ramREN=ramWEN=0; ramaddr=ramstore=0; starve_cnt=0; tcnt=0; halt_pend=0; err=0; halted=0. iwait=dwait=1; iload=dload=0.
- **States:** IDLE, IACC, DACC, HALTED. State and all registers are updated only on the CLK rising edge.
- **IDLE:**
  - halt|halt_pend → HALTED.
  - Else if (dREN|dWEN) and not (iREN and starve_cnt==STARVE_MAX) → DACC.
  - Else if iREN → IACC.
  - Else stay in IDLE.
- **Grant registration:**
  - On entry to IACC, ramaddr←iaddr and ramREN←1.
  - On entry to DACC, ramaddr←daddr and ramstore←dstore. If dWEN=1, ramWEN←1 and ramREN←0, even when dREN=1 as well. Otherwise ramREN←1.
  - Requester inputs are ignored for the rest of the access.
- **Access states:**
  - tcnt increments every cycle.
  - If ram_ready=1, the access completes combinationally in that cycle:
    - IACC: iwait=0 and iload=ramload.
    - DACC: dwait=0, and dload=ramload for reads.
  - Next state is IDLE, with ramREN/ramWEN cleared and tcnt cleared. The mandatory IDLE cycle prevents re-granting a stale request.
  - Minimum transaction is 2 cycles (request seen in IDLE, completion in the next cycle). Back-to-back transactions take 1 cycle + RAM latency each.
  - Completion is still signalled if the requester dropped its enable mid-access.
- **Timeout:** if tcnt reaches TIMEOUT-1 with no ram_ready, set err=1 (sticky until RST) and go to IDLE. There is no completion pulse and the wait outputs stay 1.
- **starve_cnt:**
  - On DACC completion with iREN=1: increments, saturating at STARVE_MAX.
  - On IACC completion, or any IDLE cycle with iREN=0: cleared.
- **halt:**
  - Sampled every cycle; halt_pend←1 if it is seen during IACC or DACC.
  - The in-flight access completes normally, then the FSM goes IDLE → HALTED.
  - HALTED: ramREN=ramWEN=0, iwait=dwait=1, halted=1. Only RST exits HALTED.
- **Reset mid-access:** the access is dropped with no completion pulse. ram enables are 0 after the edge.
- **ram_ready in IDLE or HALTED** is ignored.

Test Plan:
1. iREN=1, iaddr=0x40, RAM ready after 3 access cycles with ramload=0x8C010004 → ramREN=1 and ramaddr=0x40 from cycle 1; iwait=0 and iload=0x8C010004 in cycle 3 only; IDLE in cycle 4.
2. iREN=1 and dWEN=1 (daddr=0x100, dstore=0xDEADBEEF) together, ram_ready immediate → DACC granted first with ramWEN=1, ramREN=0, ramstore=0xDEADBEEF; IACC follows after one IDLE cycle.
3. iREN held high, dREN held high, ram_ready=1 always, STARVE_MAX=4 → grant order D,D,D,D,I,D,… (each separated by IDLE); starve_cnt returns to 0 after the I grant.
4. dREN=1 and dWEN=1 simultaneously → write only: ramWEN=1, ramREN=0.
5. ram_ready held 0 for TIMEOUT=64 cycles → err=1 at the 64th access cycle, return to IDLE, dwait stays 1; err remains 1 until RST.
6. halt pulsed during DACC, RAM ready 2 cycles later → data completes, then IDLE, then HALTED with halted=1 while iREN requests are ignored; RST asserted mid-IACC → IDLE next edge with ramREN=0 and no iwait=0 pulse.
